// File: rtl/propagation_controller.sv
// rtl/propagation_controller.sv - fixpoint propagation driver with a three-colour reasoning core and cost totals
module reasoning_core #(
    parameter int NODES        = 9,
    parameter int MU_PRECISION = 16
) (
    input  logic [3*NODES-1:0]     masks,
    input  logic [NODES*NODES-1:0] adjacency,
    input  logic [32*NODES-1:0]    node_question_bits,
    output logic [3*NODES-1:0]     forced_masks,
    output logic                   force_valid,
    output logic [31:0]            question_bits,
    output logic [31:0]            information_gain_q16,
    output logic [15:0]            activity_count
);
    // log2(3) in Q32, rescaled to the requested fraction width
    localparam logic [63:0] LOG2_3_Q32 = 64'd6807362107;
    localparam logic [31:0] GAIN_TWO   = 32'd1 << MU_PRECISION;
    localparam logic [31:0] GAIN_THREE = 32'(LOG2_3_Q32 >> (32 - MU_PRECISION));

    logic [NODES-1:0] single;
    logic [NODES-1:0] newly;
    logic [2:0]       elim;
    logic [2:0]       cand;
    logic [39:0]      qsum;
    logic [39:0]      isum;

    always_comb begin
        single       = '0;
        newly        = '0;
        elim         = '0;
        cand         = '0;
        qsum         = '0;
        isum         = '0;
        forced_masks = '0;
        activity_count = '0;
        for (int i = 0; i < NODES; i++) begin
            single[i] = $onehot(masks[3*i +: 3]);
        end
        for (int i = 0; i < NODES; i++) begin
            elim = '0;
            for (int j = 0; j < NODES; j++) begin
                if (adjacency[i*NODES + j] && single[j]) begin
                    elim = elim | masks[3*j +: 3];
                    if (!single[i]) begin
                        activity_count = activity_count + 16'd1;
                    end
                end
            end
            cand = masks[3*i +: 3] & ~elim;
            forced_masks[3*i +: 3] = cand;
            newly[i] = !single[i] && $onehot(cand);
            if (newly[i]) begin
                qsum = qsum + 40'(node_question_bits[32*i +: 32]);
                isum = isum + 40'(($countones(masks[3*i +: 3]) == 3) ? GAIN_THREE : GAIN_TWO);
            end
        end
        force_valid          = |newly;
        question_bits        = (|qsum[39:32]) ? 32'hFFFF_FFFF : qsum[31:0];
        information_gain_q16 = (|isum[39:32]) ? 32'hFFFF_FFFF : isum[31:0];
    end
endmodule

module propagation_controller #(
    parameter int NODES        = 9,
    parameter int MU_PRECISION = 16,
    parameter int MAX_ITERS    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3*NODES-1:0]     init_masks,
    input  logic [NODES*NODES-1:0] adjacency,
    input  logic [32*NODES-1:0]    node_question_bits,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             status,
    output logic [3*NODES-1:0]     final_masks,
    output logic [NODES-1:0]       conflict_nodes,
    output logic [7:0]             iterations,
    output logic [31:0]            mu_question_total,
    output logic [31:0]            mu_info_total_q16,
    output logic [15:0]            activity_total
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [3*NODES-1:0]     masks_q, masks_d;
    logic [NODES*NODES-1:0] adj_q, adj_d;
    logic [32*NODES-1:0]    qbits_q, qbits_d;
    logic [NODES-1:0]       conflict_q, conflict_d;
    logic [1:0]             status_q, status_d;
    logic [7:0]             iter_q, iter_d;
    logic [31:0]            qtot_q, qtot_d;
    logic [31:0]            itot_q, itot_d;
    logic [15:0]            atot_q, atot_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [3*NODES-1:0] forced_masks;
    logic               force_valid;
    logic [31:0]        core_qbits;
    logic [31:0]        core_info;
    logic [15:0]        core_act;
    logic [NODES-1:0]   cand_zero;

    reasoning_core #(
        .NODES        (NODES),
        .MU_PRECISION (MU_PRECISION)
    ) u_core (
        .masks                (masks_q),
        .adjacency            (adj_q),
        .node_question_bits   (qbits_q),
        .forced_masks         (forced_masks),
        .force_valid          (force_valid),
        .question_bits        (core_qbits),
        .information_gain_q16 (core_info),
        .activity_count       (core_act)
    );

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        cand_zero = '0;
        for (int i = 0; i < NODES; i++) begin
            cand_zero[i] = (forced_masks[3*i +: 3] == 3'b000);
        end
    end

    always_comb begin
        state_d    = state_q;
        masks_d    = masks_q;
        adj_d      = adj_q;
        qbits_d    = qbits_q;
        conflict_d = conflict_q;
        status_d   = status_q;
        iter_d     = iter_q;
        qtot_d     = qtot_q;
        itot_d     = itot_q;
        atot_d     = atot_q;
        // busy/done lag the state by one cycle so busy drops exactly as done rises
        busy_d     = (state_q == S_EVAL);
        done_d     = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    masks_d    = init_masks;
                    adj_d      = adjacency;
                    qbits_d    = node_question_bits;
                    conflict_d = '0;
                    status_d   = 2'b00;
                    iter_d     = '0;
                    qtot_d     = '0;
                    itot_d     = '0;
                    atot_d     = '0;
                    state_d    = S_EVAL;
                end
            end
            S_EVAL: begin
                if (|cand_zero) begin
                    conflict_d = cand_zero;
                    status_d   = 2'b01;
                    state_d    = S_DONE;
                end else if (!force_valid) begin
                    masks_d  = forced_masks;
                    status_d = 2'b00;
                    state_d  = S_DONE;
                end else begin
                    masks_d = forced_masks;
                    qtot_d  = sat_add32(qtot_q, core_qbits);
                    itot_d  = sat_add32(itot_q, core_info);
                    atot_d  = sat_add16(atot_q, core_act);
                    iter_d  = iter_q + 8'd1;
                    if (iter_d == 8'(MAX_ITERS)) begin
                        status_d = 2'b10;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            masks_q    <= '0;
            adj_q      <= '0;
            qbits_q    <= '0;
            conflict_q <= '0;
            status_q   <= '0;
            iter_q     <= '0;
            qtot_q     <= '0;
            itot_q     <= '0;
            atot_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            masks_q    <= masks_d;
            adj_q      <= adj_d;
            qbits_q    <= qbits_d;
            conflict_q <= conflict_d;
            status_q   <= status_d;
            iter_q     <= iter_d;
            qtot_q     <= qtot_d;
            itot_q     <= itot_d;
            atot_q     <= atot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign status            = status_q;
    assign final_masks       = masks_q;
    assign conflict_nodes    = conflict_q;
    assign iterations        = iter_q;
    assign mu_question_total = qtot_q;
    assign mu_info_total_q16 = itot_q;
    assign activity_total    = atot_q;
endmodule

// File: tb/tb_propagation_controller.sv
// tb/tb_propagation_controller.sv - randomized and directed bench for propagation_controller against a set-level model
module tb_propagation_controller;
    localparam logic [8:0] TRI_ADJ  = 9'b011_101_110;
    localparam logic [8:0] TRI_INIT = 9'b111_011_001;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [8:0]  init_masks, adjacency;
    logic [95:0] qbits;

    logic busy_a, done_a, busy_b, done_b;
    logic [1:0]  st_a, st_b;
    logic [8:0]  fm_a, fm_b;
    logic [2:0]  cn_a, cn_b;
    logic [7:0]  it_a, it_b;
    logic [31:0] q_a, q_b, i_a, i_b;
    logic [15:0] a_a, a_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    propagation_controller #(.NODES(3), .MU_PRECISION(16), .MAX_ITERS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_masks(init_masks), .adjacency(adjacency),
        .node_question_bits(qbits), .busy(busy_a), .done(done_a), .status(st_a), .final_masks(fm_a),
        .conflict_nodes(cn_a), .iterations(it_a), .mu_question_total(q_a), .mu_info_total_q16(i_a),
        .activity_total(a_a));

    propagation_controller #(.NODES(3), .MU_PRECISION(16), .MAX_ITERS(1)) dut_cap (
        .clk(clk), .rst_n(rst_n), .start(start), .init_masks(init_masks), .adjacency(adjacency),
        .node_question_bits(qbits), .busy(busy_b), .done(done_b), .status(st_b), .final_masks(fm_b),
        .conflict_nodes(cn_b), .iterations(it_b), .mu_question_total(q_b), .mu_info_total_q16(i_b),
        .activity_total(a_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Set-level model: a singleton neighbour removes its colour; run ends on an empty
    // candidate, on a pass with no newly decided node, or on the iteration cap.
    task automatic model_run(input int cap, input logic [8:0] im, input logic [8:0] adj, input logic [95:0] qb,
                             output logic [8:0] fm, output logic [1:0] st, output logic [2:0] cn, output int it,
                             output longint q, output longint inf, output longint act, output int cyc);
        logic [2:0] m [3];
        logic [2:0] f [3];
        logic [2:0] elim;
        longint dq, di, da;
        int nf;
        bit stop;
        for (int i = 0; i < 3; i++) m[i] = im[3*i +: 3];
        it = 0; q = 0; inf = 0; act = 0; cn = 0; st = 0; stop = 0;
        while (!stop) begin
            for (int i = 0; i < 3; i++) begin
                elim = 0;
                for (int j = 0; j < 3; j++)
                    if (adj[i*3 + j] && $countones(m[j]) == 1) elim |= m[j];
                f[i] = m[i] & ~elim;
            end
            for (int i = 0; i < 3; i++) cn[i] = (f[i] == 0);
            if (cn != 0) begin
                st = 2'b01; stop = 1;
            end else begin
                nf = 0; dq = 0; di = 0; da = 0;
                for (int i = 0; i < 3; i++) begin
                    if ($countones(m[i]) != 1 && $countones(f[i]) == 1) begin
                        nf++;
                        dq += longint'(qb[32*i +: 32]);
                        di += ($countones(m[i]) == 2) ? 65536 : 103872;
                    end
                    for (int j = 0; j < 3; j++)
                        if (adj[i*3 + j] && $countones(m[j]) == 1 && $countones(m[i]) != 1) da++;
                end
                for (int i = 0; i < 3; i++) m[i] = f[i];
                if (nf == 0) begin
                    st = 2'b00; stop = 1;
                end else begin
                    q   = (q + dq > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : q + dq;
                    inf = (inf + di > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : inf + di;
                    act = (act + da > 64'hFFFF) ? 64'hFFFF : act + da;
                    it++;
                    if (it == cap) begin st = 2'b10; stop = 1; end
                end
            end
        end
        fm  = {m[2], m[1], m[0]};
        cyc = (st == 2'b10) ? cap + 1 : it + 2;
    endtask

    task automatic run_case(input string tag, input bit disturb);
        logic [8:0] fmA, fmB; logic [1:0] stA, stB; logic [2:0] cnA, cnB;
        int itA, itB, cyA, cyB, lim;
        longint qA, qB, iA, iB, aA, aB;
        model_run(16, init_masks, adjacency, qbits, fmA, stA, cnA, itA, qA, iA, aA, cyA);
        model_run(1, init_masks, adjacency, qbits, fmB, stB, cnB, itB, qB, iB, aB, cyB);
        lim = ((cyA > cyB) ? cyA : cyB) + 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= lim; n++) begin
            @(negedge clk);
            chk($sformatf("%s_busy_n%0d", tag, n), busy_a, (n < cyA));
            chk($sformatf("%s_done_n%0d", tag, n), done_a, (n == cyA));
            chk($sformatf("%s_cap_done_n%0d", tag, n), done_b, (n == cyB));
            if (n == cyA) begin
                chk({tag, "_fm"}, fm_a, fmA);   chk({tag, "_status"}, st_a, stA);
                chk({tag, "_cn"}, cn_a, cnA);   chk({tag, "_iters"}, it_a, itA);
                chk({tag, "_q"}, q_a, qA);      chk({tag, "_info"}, i_a, iA);
                chk({tag, "_act"}, a_a, aA);
            end
            if (n == cyB) begin
                chk({tag, "_cap_fm"}, fm_b, fmB);   chk({tag, "_cap_status"}, st_b, stB);
                chk({tag, "_cap_iters"}, it_b, itB); chk({tag, "_cap_q"}, q_b, qB);
                chk({tag, "_cap_info"}, i_b, iB);    chk({tag, "_cap_act"}, a_b, aB);
            end
            if (disturb && n == 1) begin start = 1'b1; init_masks = 9'($urandom); end
            if (disturb && n == 2) start = 1'b0;
        end
    endtask

    task automatic tri_literals(input string tag);
        chk({tag, "_lit_fm"}, fm_a, 9'b100_010_001);
        chk({tag, "_lit_status"}, st_a, 2'b00);
        chk({tag, "_lit_iters"}, it_a, 2);
        chk({tag, "_lit_q"}, q_a, 16);
        chk({tag, "_lit_info"}, i_a, 131072);
        chk({tag, "_lit_act"}, a_a, 4);
        chk({tag, "_lit_cap_status"}, st_b, 2'b10);
        chk({tag, "_lit_cap_iters"}, it_b, 1);
        chk({tag, "_lit_cap_q"}, q_b, 7);
        chk({tag, "_lit_cap_info"}, i_b, 65536);
        chk({tag, "_lit_cap_fm"}, fm_b, 9'b110_010_001);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, {busy_a, done_a, st_a, fm_a, cn_a, it_a, q_a[15:0], i_a[15:0], a_a}, 0);
        chk({tag, "_a_hi"}, {q_a[31:16], i_a[31:16]}, 0);
        chk({tag, "_b"}, {busy_b, done_b, st_b, fm_b, cn_b, it_b, q_b[15:0], i_b[15:0], a_b}, 0);
    endtask

    initial begin
        logic [8:0] mfm; logic [1:0] mst; logic [2:0] mcn; int mit, mcy; longint mq, mi, ma;
        rst_n = 1'b0; start = 1'b0; init_masks = '0; adjacency = '0; qbits = '0;
        #12;
        check_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        model_run(16, TRI_INIT, TRI_ADJ, {32'd9, 32'd7, 32'd5}, mfm, mst, mcn, mit, mq, mi, ma, mcy);
        chk("model_tri_fm", mfm, 9'b100_010_001); chk("model_tri_q", mq, 16);
        chk("model_tri_info", mi, 131072);        chk("model_tri_act", ma, 4);
        chk("model_tri_cycles", mcy, 4);
        model_run(1, TRI_INIT, TRI_ADJ, {32'd9, 32'd7, 32'd5}, mfm, mst, mcn, mit, mq, mi, ma, mcy);
        chk("model_cap_status", mst, 2'b10); chk("model_cap_cycles", mcy, 2);
        model_run(16, 9'b111_001_001, 9'b000_001_010, '0, mfm, mst, mcn, mit, mq, mi, ma, mcy);
        chk("model_conf_status", mst, 2'b01); chk("model_conf_cn", mcn, 3'b011);

        init_masks = TRI_INIT; adjacency = TRI_ADJ; qbits = {32'd9, 32'd7, 32'd5};
        run_case("tri", 1'b0);
        tri_literals("tri");

        init_masks = 9'b111_001_001; adjacency = 9'b000_001_010;
        run_case("conf", 1'b0);
        chk("conf_lit_status", st_a, 2'b01);  chk("conf_lit_cn", cn_a, 3'b011);
        chk("conf_lit_fm", fm_a, 9'b111_001_001); chk("conf_lit_iters", it_a, 0);
        chk("conf_lit_totals", {q_a, i_a, a_a[15:0]} == 0, 1'b1);

        init_masks = TRI_INIT; adjacency = TRI_ADJ; qbits = {32'h20, 32'hFFFF_FFF0, 32'd5};
        run_case("sat", 1'b0);
        chk("sat_lit_q", q_a, 32'hFFFF_FFFF); chk("sat_lit_status", st_a, 2'b00);

        qbits = {32'd9, 32'd7, 32'd5};
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        #1 check_zero("midrun_reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("midrun_nodone_%0d", k), {done_a, done_b}, 2'b00);
        end
        rst_n = 1'b1;
        run_case("after_reset", 1'b0);
        tri_literals("after_reset");

        init_masks = TRI_INIT;
        run_case("disturb", 1'b1);
        tri_literals("disturb");

        for (int r = 0; r < 40; r++) begin
            adjacency = 9'($urandom) & TRI_ADJ;
            if (r % 8 == 0) adjacency[4] = 1'b1;
            for (int i = 0; i < 3; i++) init_masks[3*i +: 3] = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++)
                qbits[32*i +: 32] = (r % 3 == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : 32'($urandom_range(0, 1000));
            run_case($sformatf("rnd%0d", r), (r % 5 == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/propagation_controller.md
Name: propagation_controller

Overview:
- Sequential driver for the combinational three-colour reasoning core; instantiates one reasoning_core internally.
- Iterates constraint propagation to a fixpoint, conflict, or iteration cap.
- Accumulates μ-spec v2.0 cost terms (question bits, Q16 information gain, activity) across iterations.
- Sits between the host/solver front end, which loads a graph and initial masks, and downstream μ-ledger logic, which reads the totals.

Parameters:
- NODES, 9, vertex count; passed to reasoning_core.
- MU_PRECISION, 16, fixed-point fraction bits; passed to reasoning_core.
- MAX_ITERS, 16, maximum propagation iterations per run (1..255).

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled in IDLE only
- init_masks  in  3*NODES  initial one-hot-per-colour masks, node i at bits [3i+2:3i]
- adjacency  in  NODES*NODES  adjacency, bit i*NODES+j set when j constrains i
- node_question_bits  in  32*NODES  per-node question-bit cost
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at run end
- status  out  2  00 converged, 01 conflict, 10 iteration limit; held until next start
- final_masks  out  3*NODES  mask state at run end
- conflict_nodes  out  NODES  nodes whose candidate mask went to 000
- iterations  out  8  count of committed propagation iterations
- mu_question_total  out  32  saturating sum of core question_bits
- mu_info_total_q16  out  32  saturating sum of core information_gain_q16
- activity_total  out  16  saturating sum of core activity_count

Behaviour:
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - All outputs and internal registers go to 0.
  - Applies immediately, including mid-run; no partial results survive.
- State IDLE:
  - busy=0.
  - On start=1: latch init_masks into the mask register; latch adjacency and node_question_bits into shadow registers.
  - Clear iterations, totals, conflict_nodes and status; go to EVAL.
  - Inputs are not sampled again during the run.
- State EVAL:
  - busy=1; one core evaluation per cycle on the registered masks and shadow registers.
  - Conflict check: any node with candidate (forced_masks slice) == 000.
    - Set conflict_nodes for those nodes; status=01.
    - Masks stay unchanged; no accumulation this cycle; go to DONE.
  - Else if force_valid == 0:
    - Masks <= forced_masks, capturing non-forcing reductions; no accumulation.
    - status=00; go to DONE.
  - Else (commit):
    - Masks <= forced_masks.
    - Each total += the matching core output, saturating at all-ones; activity is zero-extended.
    - iterations += 1.
    - If the new iterations value == MAX_ITERS: status=10, go to DONE; otherwise stay in EVAL.
  - A conflict takes precedence over a commit in the same cycle.
- State DONE:
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- final_masks mirrors the mask register continuously; totals and status stay stable from DONE until the next accepted start.
- start during EVAL or DONE is ignored.
- Latency: a run with k commits ends with done asserted (k+2) cycles after the start-sampling edge.
  - Exception: runs ending on the cap take MAX_ITERS+1 cycles.
- Saturation: each 32-bit add clamps to 32'hFFFF_FFFF; activity clamps to 16'hFFFF; no wrap-around.

Test Plan:
- NODES=3, triangle (all off-diagonal adjacency set), init {n2,n1,n0}={111,011,001}, qbits {9,7,5}, start -> two commits, then converged.
  - Required: final_masks=9'b100_010_001, status=00, iterations=2, mu_question_total=16, mu_info_total_q16=131072, activity_total=4.
  - Required: done pulses 4 cycles after start.
- NODES=3, edge 0-1 only, init n0=001, n1=001, n2=111 -> first EVAL flags conflict.
  - Required: status=01, conflict_nodes=3'b011, totals 0, iterations 0, final_masks equal to init_masks.
- Triangle case with MAX_ITERS=1.
  - Required: status=10, iterations=1, mu_question_total=7, mu_info_total_q16=65536, final_masks=9'b110_010_001.
- Triangle case with qbits n1=32'hFFFF_FFF0, n2=32'h20.
  - Required: mu_question_total=32'hFFFF_FFFF, status=00.
- Deassert rst_n during the second EVAL cycle of the triangle run.
  - Required: all outputs 0 immediately, no done pulse.
  - Required: after release, a new start gives the case 1 results.
- Pulse start again during EVAL, and change init_masks mid-run.
  - Required: ignored; results identical to case 1; busy falls the cycle done rises.
